// File: rtl/dmem_stage_ctrl.sv
// Y86-64 memory-stage controller: decodes the M-stage memory op, checks the address and runs a req/ack RAM cycle.
// Optional: define DMEM_TIMEOUT_EN to abort a request that waits TIMEOUT cycles without ack.
module dmem_stage_ctrl #(
    parameter int MEM_BYTES = 65536
`ifdef DMEM_TIMEOUT_EN
    , parameter int TIMEOUT = 16
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  M_icode,
    input  logic [2:0]  M_stat,
    input  logic [63:0] M_valE,
    input  logic [63:0] M_valA,
    input  logic        W_stall,
    output logic [63:0] m_valM,
    output logic [2:0]  m_stat,
    output logic        m_stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [63:0] bus_addr,
    output logic [63:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [63:0] bus_rdata,
    input  logic        bus_err
);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_ADR = 3'd3;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state, stateNext;
    logic        isMem, isRead, memActive, addrOk;
    logic [63:0] opAddr;
    logic        startReq, badAddr, ackTake, timeoutHit;
    logic        readReg, errReg;
    logic [63:0] rdataReg;

`ifdef DMEM_TIMEOUT_EN
    logic [7:0]  waitCnt;
`endif

    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        isMem  = 1'b0;
        isRead = 1'b0;
        opAddr = M_valE;
        case (M_icode)
            4'h5:             begin isMem = 1'b1; isRead = 1'b1; end
            4'h4, 4'hA, 4'h8: isMem = 1'b1;
            4'h9, 4'hB:       begin isMem = 1'b1; isRead = 1'b1; opAddr = M_valA; end
            default:          ;
        endcase
    end

    assign memActive = isMem && (M_stat == STAT_AOK);
    assign addrOk    = (opAddr[2:0] == 3'd0) && (opAddr < 64'(MEM_BYTES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext  = state;
        startReq   = 1'b0;
        badAddr    = 1'b0;
        ackTake    = 1'b0;
        timeoutHit = 1'b0;
        m_stall    = 1'b0;
        m_valM     = 64'd0;
        m_stat     = M_stat;
        case (state)
            IDLE: begin
                if (memActive) begin
                    m_stall = 1'b1;
                    if (addrOk) begin
                        stateNext = REQ;
                        startReq  = 1'b1;
                    end else begin
                        stateNext = DONE;
                        badAddr   = 1'b1;
                    end
                end
            end
            REQ: begin
                m_stall = 1'b1;
                if (bus_ack) begin
                    stateNext = DONE;
                    ackTake   = 1'b1;
                end
`ifdef DMEM_TIMEOUT_EN
                else if (waitCnt == 8'(TIMEOUT - 1)) begin
                    stateNext  = DONE;
                    timeoutHit = 1'b1;
                end
`endif
            end
            DONE: begin
                m_stat = errReg ? STAT_ADR : M_stat;
                m_valM = (readReg && !errReg) ? rdataReg : 64'd0;
                if (!W_stall) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        // Reset forces the pipeline-facing outputs low without waiting for a clock edge.
        if (!rst_n) begin
            m_stall = 1'b0;
            m_valM  = 64'd0;
            m_stat  = 3'd0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 64'd0;
            bus_wdata <= 64'd0;
            readReg   <= 1'b0;
            errReg    <= 1'b0;
            rdataReg  <= 64'd0;
        end else if (startReq) begin
            bus_req   <= 1'b1;
            bus_we    <= !isRead;
            bus_addr  <= opAddr;
            bus_wdata <= isRead ? 64'd0 : M_valA;
            readReg   <= isRead;
            errReg    <= 1'b0;
        end else if (badAddr) begin
            readReg   <= isRead;
            errReg    <= 1'b1;
        end else if (ackTake) begin
            bus_req   <= 1'b0;
            rdataReg  <= bus_rdata;
            errReg    <= bus_err;
        end else if (timeoutHit) begin
            bus_req   <= 1'b0;
            errReg    <= 1'b1;
        end
    end

`ifdef DMEM_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       waitCnt <= 8'd0;
        else if (startReq)                waitCnt <= 8'd0;
        else if (state == REQ && !bus_ack) waitCnt <= waitCnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_dmem_stage_ctrl.sv
// Scoreboard bench for dmem_stage_ctrl: a RAM responder with programmable wait states, expected results queued per op.
module tb_dmem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  M_icode;
    logic [2:0]  M_stat;
    logic [63:0] M_valE, M_valA;
    logic        W_stall;
    logic [63:0] m_valM;
    logic [2:0]  m_stat;
    logic        m_stall;
    logic        bus_req, bus_we;
    logic [63:0] bus_addr, bus_wdata;
    logic        bus_ack;
    logic [63:0] bus_rdata;
    logic        bus_err;

    int checkCount = 0;
    int errorCount = 0;

    typedef struct {
        logic [63:0] valM;
        logic [2:0]  stat;
        int          stall;
        int          req;
    } exp_t;

    exp_t sbQ[$];

    dmem_stage_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .M_icode(M_icode), .M_stat(M_stat), .M_valE(M_valE), .M_valA(M_valA),
        .W_stall(W_stall),
        .m_valM(m_valM), .m_stat(m_stat), .m_stall(m_stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called #1 after a posedge with the DUT in IDLE; returns #1 after the edge that leaves DONE.
    task automatic doOp(input logic [3:0] icode, input logic [2:0] stat,
                        input logic [63:0] valE, input logic [63:0] valA,
                        input int waits, input logic [63:0] rdata, input logic berr,
                        input logic expWe, input logic [63:0] expAddr, input logic [63:0] expWdata,
                        input int expStall, input int expReq,
                        input logic [63:0] expValM, input logic [2:0] expStat, input int hold);
        exp_t e;
        int   stallCnt = 0;
        int   reqCnt   = 0;
        bit   done     = 0;
        sbQ.push_back('{valM: expValM, stat: expStat, stall: expStall, req: expReq});
        M_icode = icode; M_stat = stat; M_valE = valE; M_valA = valA;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk);
            if (bus_req) begin
                reqCnt++;
                check("bus_we", 64'(bus_we), 64'(expWe));
                check("bus_addr", bus_addr, expAddr);
                check("bus_wdata", bus_wdata, expWdata);
                bus_ack   = (reqCnt == waits + 1);
                bus_rdata = rdata;
                bus_err   = berr;
            end else begin
                bus_ack = 1'b0;
            end
            if (m_stall) begin
                stallCnt++;
            end else begin
                e = sbQ.pop_front();
                check("m_valM", m_valM, e.valM);
                check("m_stat", 64'(m_stat), 64'(e.stat));
                check("stall_cycles", 64'(stallCnt), 64'(e.stall));
                check("req_cycles", 64'(reqCnt), 64'(e.req));
                done = 1;
                if (hold > 0) begin
                    W_stall = 1'b1;
                    for (int h = 0; h < hold; h++) begin
                        @(posedge clk);
                        @(negedge clk);
                        check("hold_valM", m_valM, e.valM);
                        check("hold_stall", 64'(m_stall), 64'd0);
                    end
                    W_stall = 1'b0;
                end
            end
            @(posedge clk); #1;
        end
        if (!done) check("op_completes", 64'(done), 64'd1);
    endtask

    initial begin
        int stallLow;
        rst_n = 1'b0; W_stall = 1'b0;
        M_icode = 4'h5; M_stat = 3'd1; M_valE = 64'h40; M_valA = 64'd0;
        bus_ack = 1'b0; bus_rdata = 64'd0; bus_err = 1'b0;
        #12;
        check("rst_bus_req", 64'(bus_req), 64'd0);
        check("rst_m_stall", 64'(m_stall), 64'd0);
        check("rst_m_valM", m_valM, 64'd0);
        M_icode = 4'h3;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Pass-through stream, plus a stray ack that must be ignored.
        bus_ack = 1'b1;
        @(posedge clk); #1;
        check("stray_ack_req", 64'(bus_req), 64'd0);
        bus_ack = 1'b0;
        doOp(4'h3, 3'd1, 64'h10, 64'h0, 0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 0, 0, 64'h0, 3'd1, 0);
        doOp(4'h6, 3'd1, 64'h11, 64'h0, 0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 0, 0, 64'h0, 3'd1, 0);
        doOp(4'h3, 3'd1, 64'h12, 64'h0, 0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 0, 0, 64'h0, 3'd1, 0);
        // Memory icode with a non-AOK status passes through untouched.
        doOp(4'h5, 3'd4, 64'h40, 64'h0, 0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 0, 0, 64'h0, 3'd4, 0);

        // mrmovq, ack in first REQ cycle.
        doOp(4'h5, 3'd1, 64'h40, 64'h0, 0, 64'h1234, 1'b0, 1'b0, 64'h40, 64'h0, 2, 1, 64'h1234, 3'd1, 0);
        // pushq, three wait cycles.
        doOp(4'hA, 3'd1, 64'h1F8, 64'hAB, 3, 64'hDEAD, 1'b0, 1'b1, 64'h1F8, 64'hAB, 5, 4, 64'h0, 3'd1, 0);
        // call writes valP, one wait.
        doOp(4'h8, 3'd1, 64'h100, 64'h77, 1, 64'h0, 1'b0, 1'b1, 64'h100, 64'h77, 3, 2, 64'h0, 3'd1, 0);
        // Misaligned and out-of-range addresses never reach the bus.
        doOp(4'h4, 3'd1, 64'h41, 64'h5, 0, 64'h0, 1'b0, 1'b1, 64'h0, 64'h0, 1, 0, 64'h0, 3'd3, 0);
        doOp(4'h5, 3'd1, 64'd65536, 64'h0, 0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 1, 0, 64'h0, 3'd3, 0);
        // Highest legal aligned address.
        doOp(4'h5, 3'd1, 64'd65528, 64'h0, 0, 64'h55, 1'b0, 1'b0, 64'd65528, 64'h0, 2, 1, 64'h55, 3'd1, 0);
        // ret at M_valA with RAM fault.
        doOp(4'h9, 3'd1, 64'h0, 64'h80, 0, 64'h99, 1'b1, 1'b0, 64'h80, 64'h0, 2, 1, 64'h0, 3'd3, 0);

`ifdef DMEM_TIMEOUT_EN
        // ret with no ack: request abandoned after 16 REQ cycles.
        doOp(4'h9, 3'd1, 64'h0, 64'h88, 1000, 64'h0, 1'b0, 1'b0, 64'h88, 64'h0, 17, 16, 64'h0, 3'd3, 0);
        M_icode = 4'h5; M_stat = 3'd1; M_valE = 64'h80;
        @(posedge clk); #1;
`else
        // ret with no ack: REQ waits indefinitely.
        M_icode = 4'h9; M_stat = 3'd1; M_valA = 64'h88;
        stallLow = 0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (!m_stall) stallLow++;
        end
        check("no_ack_stall_low_cycles", 64'(stallLow), 64'd0);
`endif
        @(posedge clk); #3;
        check("mid_req_bus_req", 64'(bus_req), 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_bus_req", 64'(bus_req), 64'd0);
        check("async_rst_m_stall", 64'(m_stall), 64'd0);
        M_icode = 4'h3;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // popq after reset, DONE held two extra cycles by W_stall.
        doOp(4'hB, 3'd1, 64'h0, 64'h200, 1, 64'hCAFE, 1'b0, 1'b0, 64'h200, 64'h0, 3, 2, 64'hCAFE, 3'd1, 2);
        // Back-to-back mrmovq immediately after.
        doOp(4'h5, 3'd1, 64'h208, 64'h0, 0, 64'hBEEF, 1'b0, 1'b0, 64'h208, 64'h0, 2, 1, 64'hBEEF, 3'd1, 0);
        doOp(4'h6, 3'd1, 64'h0, 64'h0, 0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 0, 0, 64'h0, 3'd1, 0);

        check("scoreboard_empty", 64'(sbQ.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/dmem_stage_ctrl.md
# dmem_stage_ctrl

Memory-stage controller for the Y86-64 pipeline. It sits between the M pipeline register and a multi-cycle data RAM. It decodes the memory operation from M_icode and range/alignment-checks the address. It runs a req/ack transaction on the RAM bus and freezes the pipeline with m_stall until m_valM and m_stat are final. Results go to WRITE_REG and the forwarding logic.

## Interface
- MEM_BYTES, 65536: legal byte-address span; addr >= MEM_BYTES -> ADR.
- TIMEOUT, 16: ack wait limit in REQ cycles (1..255); used only with DMEM_TIMEOUT_EN.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous and active-low.
- M_icode  in  4  M-stage icode.
- M_stat  in  3  M-stage status (AOK=1, HLT=2, ADR=3, INS=4).
- M_valE  in  64  ALU result.
- M_valA  in  64  store data / pop/ret address.
- W_stall  in  1  writeback stall from pipeline control.
- m_valM  out  64  read data, valid in DONE for reads; 0 otherwise.
- m_stat  out  3  M_stat, or ADR (3) on a memory error.
- m_stall  out  1  holds F/D/E/M registers and bubbles W.
- bus_req  out  1  RAM request, registered.
- bus_we  out  1  1 = write.
- bus_addr  out  64  byte address, 8-byte aligned.
- bus_wdata  out  64  write data.
- bus_ack  in  1  RAM completion, sampled on clk.
- bus_rdata  in  64  read data, valid with bus_ack.
- bus_err  in  1  RAM fault, valid with bus_ack.

## Operation
- Op decode. mrmovq (5) reads at M_valE. rmmovq (4) and pushq (A) write M_valA at M_valE. call (8) writes M_valA (valP) at M_valE. ret (9) and popq (B) read at M_valA. All other icodes are non-memory.
- Non-memory icode, or M_stat != AOK: pass-through. m_stall=0, m_valM=0, m_stat=M_stat, no bus activity.
- States:
  - IDLE. A memory op with a legal address -> REQ; bus_req, bus_we, bus_addr, bus_wdata are latched.
  - IDLE. A memory op with an illegal address (addr[2:0]!=0 or addr >= MEM_BYTES) -> DONE with err=1; no bus cycle.
  - REQ. bus_ack=1 -> DONE; bus_rdata and bus_err are captured and bus_req drops at that edge.
  - DONE. m_stall=0; the result is presented. W_stall=1 holds DONE, otherwise -> IDLE.
- m_stall = 1 in IDLE while a memory op is present, and in REQ.
- m_stat = ADR when err=1, else M_stat. On error m_valM=0.
- Bus signals stay stable while bus_req=1. bus_req never re-asserts in the cycle it drops.
- Reset (any state, any time): state=IDLE, all outputs 0 immediately, so an in-flight request is abandoned. The RAM must tolerate a request dropped without ack.

## Timing
- Pass-through: 0 cycles, combinational.
- Memory op with ack in the first REQ cycle: m_stall high 2 cycles, result in the 3rd (IDLE->REQ->DONE). Each extra wait cycle adds 1.
- Illegal address: m_stall high 1 cycle; DONE with ADR in the 2nd.
- Back-to-back memory ops: DONE->IDLE, then the next op starts with no gap beyond the IDLE detect cycle.
- bus_ack outside REQ is ignored.

## Configuration
- DMEM_TIMEOUT_EN defined: an 8-bit counter clears on REQ entry and increments each REQ cycle without ack. When it reaches TIMEOUT, bus_req drops and the FSM goes to DONE with err=1 (ADR).
- DMEM_TIMEOUT_EN undefined: no counter; REQ waits for bus_ack indefinitely.

## Test plan
- irmovq/opq stream (icode 3/6) with AOK -> m_stall=0 throughout, bus_req never 1, m_stat=1.
- mrmovq with M_valE=0x40, ack next cycle, rdata=0x1234 -> bus_req 1 cycle at addr 0x40 with we=0; DONE m_valM=0x1234, m_stat=1; m_stall 2 cycles.
- pushq with M_valE=0x1F8, M_valA=0xAB, ack after 3 waits -> we=1, wdata=0xAB held 4 cycles; m_stall 5 cycles.
- rmmovq at 0x41, then mrmovq at MEM_BYTES -> no bus_req for either; m_stat=3 in DONE for both; m_valM=0.
- With DMEM_TIMEOUT_EN and TIMEOUT=16, ret with no ack -> bus_req high exactly 16 cycles, then DONE with m_stat=3. Without the macro, m_stall stays 1 for 100+ cycles.
- rst_n pulled low mid-REQ -> bus_req and m_stall go 0 without a clock edge. After release, a popq completes normally; W_stall=1 in DONE holds m_valM for 2 cycles.
